ps2_host_tx: RTL

PS/2 host-to-device transmitter. It sends command bytes to the keyboard, such as reset 0xFF, set-LEDs 0xED and enable 0xF4, over the same open-drain ps2_clk/ps2_data pair that the game's keyboard receiver listens on. It runs the full host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity and stop. It then samples the device ACK. It sits beside the receiver inside main, and its drive-low outputs are OR-ed into the pad output-enables.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 80 ++++++++
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter and line sync.
//   ps2_state_e : transmitter FSM states
//   FRAME_EDGES : device clock falling edges in one host-to-device frame
//   DATA_BITS   : payload bits per frame
//   CMD_*       : common keyboard command bytes
//   odd_parity  : parity bit that makes the 9-bit {parity, data} word odd
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    localparam int FRAME_EDGES = 11;
    localparam int DATA_BITS   = 8;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- conditions the raw PS/2 pad levels for the host logic.
// Shared with the keyboard receiver.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   ps2_clk_i    : raw PS/2 clock pad level
//   ps2_data_i   : raw PS/2 data pad level
//   clk_level_o  : conditioned clock level
//   data_level_o : synchronized data level
//   clk_fe_o     : one-cycle pulse on a conditioned clock falling edge
// Build option PS2_GLITCH_FILTER_EN: the synced clock must hold a new level
// for 4 consecutive cycles before it is accepted (fe latency 6 instead of 3).
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_level_o,
    output logic data_level_o,
    output logic clk_fe_o
);

    logic clk_meta_q, clk_sync_q;
    logic data_meta_q, data_sync_q;
    logic clk_level_q;
    logic fe_q;

    // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    logic [1:0] stable_cnt_q;

    // Counts cycles where the synced clock disagrees with the accepted level;
    // the 4th disagreeing cycle commits the new level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_level_q  <= 1'b1;
            stable_cnt_q <= 2'd0;
            fe_q         <= 1'b0;
        end else if (clk_sync_q == clk_level_q) begin
            stable_cnt_q <= 2'd0;
            fe_q         <= 1'b0;
        end else if (stable_cnt_q == 2'd3) begin
            clk_level_q  <= clk_sync_q;
            stable_cnt_q <= 2'd0;
            fe_q         <= clk_level_q;
        end else begin
            stable_cnt_q <= stable_cnt_q + 2'd1;
            fe_q         <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_level_q <= 1'b1;
            fe_q        <= 1'b0;
        end else begin
            clk_level_q <= clk_sync_q;
            fe_q        <= clk_level_q & ~clk_sync_q;
        end
    end
`endif

    assign clk_level_o  = clk_level_q;
    assign data_level_o = data_sync_q;
    assign clk_fe_o     = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Runs clock inhibit, request-to-send, 8 data bits LSB first, odd parity,
// stop, then samples the device ACK on the 11th device clock falling edge.
//   board_clk          : system clock
//   reset_n            : asynchronous active-low reset
//   tx_data/tx_valid   : command byte request, taken when tx_valid & tx_ready
//   tx_ready           : high in IDLE (except during the done cycle)
//   ps2_clk_in/data_in : raw pad levels
//   ps2_*_drive_low    : open-drain pull-down enables
//   rx_inhibit         : high while a transfer is in progress
//   done/ack_ok/err    : one-cycle completion pulse with result
// Build option PS2_GLITCH_FILTER_EN is handled inside ps2_line_sync.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       board_clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic clk_level, data_level, clk_fe;

    ps2_line_sync u_sync (
        .clk_i        (board_clk),
        .rst_ni       (reset_n),
        .ps2_clk_i    (ps2_clk_in),
        .ps2_data_i   (ps2_data_in),
        .clk_level_o  (clk_level),
        .data_level_o (data_level),
        .clk_fe_o     (clk_fe)
    );

    ps2_state_e       state_q;
    logic [8:0]       frame_q;     // {parity, data}, shifted right as bits go out
    logic [3:0]       edge_n_q;    // falling edges seen so far in SHIFT
    logic [CNT_W-1:0] cnt_q;       // inhibit length, then inter-edge timeout
    logic             released_q;  // RTS: clock line already released
    logic             ack_q;
    logic             clk_dl_q, data_dl_q;
    logic             done_q, ack_ok_q, err_q;

    logic timeout;
    assign timeout = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge board_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            edge_n_q   <= 4'd0;
            cnt_q      <= '0;
            released_q <= 1'b0;
            ack_q      <= 1'b0;
            clk_dl_q   <= 1'b0;
            data_dl_q  <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame_q   <= {odd_parity(tx_data), tx_data};
                        state_q   <= INHIBIT;
                        clk_dl_q  <= 1'b1;
                        data_dl_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                // Our own clock hold-down produces an fe here; it is ignored.
                INHIBIT: begin
                    if (cnt_q == INHIBIT_LAST) begin
                        state_q    <= RTS;
                        data_dl_q  <= 1'b1;
                        released_q <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                // First cycle keeps the clock low with data low (start bit);
                // after that the clock is released and we wait for the device.
                RTS: begin
                    if (!released_q) begin
                        clk_dl_q   <= 1'b0;
                        released_q <= 1'b1;
                        cnt_q      <= '0;
                    end else if (clk_fe) begin
                        state_q   <= SHIFT;
                        edge_n_q  <= 4'd1;
                        data_dl_q <= ~frame_q[0];
                        frame_q   <= {1'b0, frame_q[8:1]};
                        cnt_q     <= '0;
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        clk_dl_q  <= 1'b0;
                        data_dl_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SHIFT: begin
                    if (clk_fe) begin
                        edge_n_q <= edge_n_q + 4'd1;
                        cnt_q    <= '0;
                        if (edge_n_q <= 4'(DATA_BITS)) begin
                            // Edges 2..9 put data bits 1..7 and then parity.
                            data_dl_q <= ~frame_q[0];
                            frame_q   <= {1'b0, frame_q[8:1]};
                        end else if (edge_n_q == 4'(FRAME_EDGES - 1)) begin
                            ack_q     <= ~data_level;
                            data_dl_q <= 1'b0;
                            state_q   <= WAIT_IDLE;
                        end else begin
                            data_dl_q <= 1'b0;  // stop bit: release data
                        end
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        clk_dl_q  <= 1'b0;
                        data_dl_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_level && data_level) begin
                        state_q  <= IDLE;
                        done_q   <= 1'b1;
                        ack_ok_q <= ack_q;
                        err_q    <= ~ack_q;
                    end else if (clk_fe) begin
                        cnt_q <= '0;
                    end else if (timeout) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_dl_q  <= 1'b0;
                    data_dl_q <= 1'b0;
                end
            endcase
        end
    end

    // The done cycle is already in IDLE; hold off ready until it has passed.
    assign tx_ready           = (state_q == IDLE) && !done_q;
    assign rx_inhibit         = (state_q != IDLE);
    assign ps2_clk_drive_low  = clk_dl_q;
    assign ps2_data_drive_low = data_dl_q;
    assign done               = done_q;
    assign ack_ok             = ack_ok_q;
    assign err                = err_q;

endmodule
